hex_display_scan_ctrl: RTL
==========================

// Module: hex_display_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
//  Accepts a packed hex value over a valid/ready handshake and double-buffers it,
//  committing it only at frame boundaries so the display never tears.
//  Drives one shared hex->7seg decoder and walks the anode enables digit by digit.
//  Sits between the ALU/result datapath and the board's HEX/anode pins.
// PARAMETERS
//  NUM_DIGITS   4      number of scanned digits (>=2)
//  REFRESH_DIV  50000  clk cycles each digit stays lit (>=2)
//  DATA_W       4*NUM_DIGITS  packed nibble width (derived, not overridden)
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  rst_n      in   1           synchronous reset, active low
//  in_valid   in   1           in_data is offered this cycle
//  in_ready   out  1           controller can take in_data (= no update pending)
//  in_data    in   DATA_W      nibble i (bits 4i+3:4i) shown on digit i
//  disp_en    in   1           0: all anodes off, scanning/handshake continue
//  blank_lz   in   1           1: blank leading-zero digits (digit 0 always shown)
//  an_n       out  NUM_DIGITS  anode enables, active low, one-hot-low when lit
//  seg_n      out  7           segments gfedcba (bit6=g), active low
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=BLANK, pending=0, shadow=0, tick=0, digit=0;
//   an_n=all 1, seg_n=7'h7F, in_ready=1. Reset mid-frame discards pending and shadow data.
//  Handshake: transfer when in_valid&&in_ready at an edge; pend_buf<=in_data, pending<=1.
//   in_ready = !pending (combinational from the register). in_valid while !in_ready: ignored, no stall state.
//  FSM BLANK: no scanning, outputs held off. When pending=1: shadow<=pend_buf, pending<=0,
//   tick<=0, digit<=0, go to SCAN. Registered outputs show digit 0 one edge later.
//   Accept at edge k -> commit at edge k+1 -> an_n/seg_n valid after edge k+2.
//  FSM SCAN: tick counts 0..REFRESH_DIV-1 and wraps. At tick==REFRESH_DIV-1, digit advances,
//   wrapping NUM_DIGITS-1 -> 0. That wrap is the frame boundary.
//   At the frame boundary, if pending: shadow<=pend_buf, pending<=0 in the same edge, so the new frame starts with new data.
//   SCAN never returns to BLANK except through reset.
//  Same-edge boundary commit and new in_valid: in_ready was 0, so not accepted; ready rises next cycle.
//  Outputs registered, 1-cycle latency from digit/shadow: an_n[digit]=0, others 1;
//   seg_n=decode(shadow nibble[digit]).
//  Leading-zero blank (blank_lz=1): digit i>0 blanked (seg_n=7'h7F, anode still driven)
//   iff nibbles i..NUM_DIGITS-1 are all 0. blank_lz is sampled live every cycle.
//  disp_en=0: an_n=all 1 and seg_n=7'h7F on the next edge; tick/digit/handshake unaffected.
//  Decode table 0-F (active low): 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
// STRUCTURE
//  Package seg7_pkg: SEG_BLANK=7'h7F; function hex2seg(logic[3:0])->logic[6:0] holding the table above;
//   typedef enum logic {BLANK, SCAN} scan_state_t.
//  One sub-module: hex7seg_digit (single-nibble combinational decoder built on hex2seg),
//   instantiated once and shared across digits.
//  Counter width $clog2(REFRESH_DIV); digit width $clog2(NUM_DIGITS).
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4)
//  Reset then idle 20 cycles -> an_n=4'hF, seg_n=7'h7F, in_ready=1 throughout.
//  Send 16'h1A3F at edge k -> after edge k+2: an_n=4'b1110, seg_n=7'h0E.
//   Each 4 cycles, the next digit shows 30, 08, 79 with an_n 1101/1011/0111.
//  Mid-frame (digit 1), send 16'h0000 -> in_ready=0 until the wrap 3->0. Remaining digits still show 1A3F.
//   The new frame shows 40 on all digits; in_ready=1 after the wrap edge.
//  blank_lz=1 with data 16'h0050 -> digits 3,2 seg_n=7'h7F; digit1=12, digit0=40.
//   With data 16'h0000 -> only digit 0 shows 40.
//  in_valid held high with changing data while pending -> only the value at the accepting edge is displayed.
//   Second offer accepted exactly one cycle after the boundary commit.
//  Assert rst_n=0 for one edge mid-scan with pending=1 -> outputs off, in_ready=1, pending data never displayed.

Source files
------------

// File: rtl/hex_display_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: the active-low segment
// encoding, the blank pattern and the controller state type.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    BLANK,
    SCAN
  } scan_state_t;

  // Segment order gfedcba (bit 6 = g), active low, common-anode digits.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_scan_ctrl_if.sv
// Valid/ready write channel carrying one packed nibble per display digit.
interface hex_display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int DATA_W = 4 * NUM_DIGITS;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/hex_display_scan_ctrl_hex7seg_digit.sv
// Single-nibble hex to 7-segment decoder with a blank override; one instance is
// time-shared across all scanned digits.
module hex7seg_digit
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_n
);

  assign seg_n = blank ? SEG_BLANK : hex2seg(nibble);

endmodule

// File: rtl/hex_display_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits. New data is
// double-buffered and committed only at frame boundaries so the display never tears.
module hex_display_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hex_display_scan_ctrl_if.slave  in_if,
  input  logic                    disp_en,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int DIG_W  = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  scan_state_t           state_q,    state_d;
  logic                  pending_q,  pending_d;
  logic [DATA_W-1:0]     pend_buf_q, pend_buf_d;
  logic [DATA_W-1:0]     shadow_q,   shadow_d;
  logic [CNT_W-1:0]      tick_q,     tick_d;
  logic [DIG_W-1:0]      digit_q,    digit_d;
  logic [NUM_DIGITS-1:0] an_n_q,     an_n_d;
  logic [6:0]            seg_n_q,    seg_n_d;

  logic                  accept;
  logic [3:0]            cur_nibble;
  logic                  upper_zero;
  logic                  lz_blank;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] an_lit;

  assign in_if.in_ready = !pending_q;
  assign accept         = in_if.in_valid && !pending_q;

  assign cur_nibble = shadow_q[{digit_q, 2'b00} +: 4];
  assign an_lit     = ~(NUM_DIGITS'(1) << digit_q);

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(digit_q) && shadow_q[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
  end

  assign lz_blank = blank_lz && (digit_q != '0) && upper_zero;

  hex7seg_digit u_dec (
    .nibble (cur_nibble),
    .blank  (lz_blank),
    .seg_n  (dec_seg)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    pending_d  = pending_q;
    pend_buf_d = pend_buf_q;
    shadow_d   = shadow_q;
    tick_d     = tick_q;
    digit_d    = digit_q;
    an_n_d     = '1;
    seg_n_d    = SEG_BLANK;

    if (accept) begin
      pend_buf_d = in_if.in_data;
      pending_d  = 1'b1;
    end

    // Accept needs pending_q=0 and every commit needs pending_q=1, so they never collide.
    case (state_q)
      BLANK: begin
        if (pending_q) begin
          shadow_d  = pend_buf_q;
          pending_d = 1'b0;
          tick_d    = '0;
          digit_d   = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (digit_q == DIG_LAST) begin
            digit_d = '0;
            if (pending_q) begin
              shadow_d  = pend_buf_q;
              pending_d = 1'b0;
            end
          end else begin
            digit_d = digit_q + DIG_W'(1);
          end
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      default: state_d = BLANK;
    endcase

    if (state_q == SCAN && disp_en) begin
      an_n_d  = an_lit;
      seg_n_d = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q    <= BLANK;
      pending_q  <= 1'b0;
      pend_buf_q <= '0;
      shadow_q   <= '0;
      tick_q     <= '0;
      digit_q    <= '0;
      an_n_q     <= '1;
      seg_n_q    <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pend_buf_q <= pend_buf_d;
      shadow_q   <= shadow_d;
      tick_q     <= tick_d;
      digit_q    <= digit_d;
      an_n_q     <= an_n_d;
      seg_n_q    <= seg_n_d;
    end
  end

  assign an_n  = an_n_q;
  assign seg_n = seg_n_q;

endmodule
